// File: rtl/miter_stream_cmp.sv
// miter_stream_cmp: delayed gold-vs-gate lane comparator with masking, sticky flags and first-failure capture
module miter_stream_cmp #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int LAT       = 2,
    parameter int CNT_W     = 16,
    parameter bit STOP_FAIL = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic [CHANNELS*WIDTH-1:0]    gold,
    input  logic [CHANNELS*WIDTH-1:0]    gate,
    input  logic [CHANNELS*WIDTH-1:0]    gold_xmask,
    input  logic [CHANNELS-1:0]          chan_en,
    output logic                         mismatch,
    output logic [CHANNELS-1:0]          fail_flags,
    output logic [CNT_W-1:0]             mis_count,
    output logic [$clog2(CHANNELS):0]    first_chan,
    output logic [CNT_W-1:0]             first_stamp,
    output logic [WIDTH-1:0]             first_gold,
    output logic [WIDTH-1:0]             first_gate,
    output logic [1:0]                   state_o
);
    localparam int N  = CHANNELS * WIDTH;
    localparam int CW = $clog2(CHANNELS) + 1;
    localparam int WW = $clog2(LAT + 2);

    typedef enum logic [1:0] {IDLE = 2'd0, WARMUP = 2'd1, CHECK = 2'd2, FAILED = 2'd3} state_t;

    state_t              state_q, state_d;
    logic [WW-1:0]       wcnt_q, wcnt_d;
    logic                mismatch_q, mismatch_d;
    logic [CHANNELS-1:0] fail_flags_q, fail_flags_d;
    logic [CNT_W-1:0]    mis_count_q, mis_count_d;
    logic [CNT_W-1:0]    stamp_q, stamp_d;
    logic [CW-1:0]       first_chan_q, first_chan_d;
    logic [CNT_W-1:0]    first_stamp_q, first_stamp_d;
    logic [WIDTH-1:0]    first_gold_q, first_gold_d;
    logic [WIDTH-1:0]    first_gate_q, first_gate_d;

    logic [N-1:0]        gold_dly, xmask_dly;
    logic                valid_dly;
    logic [CHANNELS-1:0] lane_mis;
    logic [CW-1:0]       first_idx;
    logic                cmp, any_mis;

    generate
        if (LAT == 0) begin : g_direct
            assign gold_dly  = gold;
            assign xmask_dly = gold_xmask;
            assign valid_dly = in_valid;
        end else begin : g_pipe
            logic [N-1:0]   gold_q [LAT];
            logic [N-1:0]   gold_d [LAT];
            logic [N-1:0]   xmask_q [LAT];
            logic [N-1:0]   xmask_d [LAT];
            logic [LAT-1:0] valid_q, valid_d;
            // shift the gold sample, its mask and valid one stage per cycle; clear empties the valid bits
            always_comb begin
                gold_d[0]  = gold;
                xmask_d[0] = gold_xmask;
                valid_d[0] = in_valid & ~clear;
                for (int s = 1; s < LAT; s++) begin
                    gold_d[s]  = gold_q[s-1];
                    xmask_d[s] = xmask_q[s-1];
                    valid_d[s] = valid_q[s-1] & ~clear;
                end
            end
            // sample data is qualified by the valid bits, so it needs no reset
            always_ff @(posedge clk) begin
                gold_q  <= gold_d;
                xmask_q <= xmask_d;
            end
            // valid bits of the gold pipe
            always_ff @(posedge clk or posedge rst) begin
                if (rst) valid_q <= '0;
                else     valid_q <= valid_d;
            end
            assign gold_dly  = gold_q[LAT-1];
            assign xmask_dly = xmask_q[LAT-1];
            assign valid_dly = valid_q[LAT-1];
        end
    endgenerate

    assign cmp     = valid_dly & in_valid & (state_q == CHECK | (state_q == FAILED & !STOP_FAIL));
    assign any_mis = cmp & |lane_mis;

    // per-lane masked comparison and the lowest failing lane
    always_comb begin
        lane_mis  = '0;
        first_idx = '0;
        for (int i = 0; i < CHANNELS; i++)
            lane_mis[i] = chan_en[i] & |((gold_dly[i*WIDTH +: WIDTH] ^ gate[i*WIDTH +: WIDTH]) & ~xmask_dly[i*WIDTH +: WIDTH]);
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (lane_mis[i]) first_idx = CW'(i);
    end

    // next state, statistics and first-failure capture; clear overrides everything
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        mismatch_d    = any_mis;
        fail_flags_d  = fail_flags_q | (cmp ? lane_mis : '0);
        mis_count_d   = mis_count_q + CNT_W'(any_mis & ~&mis_count_q);
        stamp_d       = stamp_q + CNT_W'(cmp & ~&stamp_q);
        first_chan_d  = first_chan_q;
        first_stamp_d = first_stamp_q;
        first_gold_d  = first_gold_q;
        first_gate_d  = first_gate_q;
        if (state_q == IDLE && arm) begin
            state_d = LAT == 0 ? CHECK : WARMUP;
            wcnt_d  = '0;
        end
        if (state_q == WARMUP && in_valid) begin
            wcnt_d  = wcnt_q + WW'(1);
            state_d = wcnt_q == WW'(LAT - 1) ? CHECK : WARMUP;
        end
        if (state_q == CHECK && any_mis) begin
            state_d       = FAILED;
            first_chan_d  = first_idx;
            first_stamp_d = stamp_q;
            first_gold_d  = gold_dly[first_idx*WIDTH +: WIDTH];
            first_gate_d  = gate[first_idx*WIDTH +: WIDTH];
        end
        if (clear) begin
            state_d       = IDLE;
            wcnt_d        = '0;
            mismatch_d    = 1'b0;
            fail_flags_d  = '0;
            mis_count_d   = '0;
            stamp_d       = '0;
            first_chan_d  = '0;
            first_stamp_d = '0;
            first_gold_d  = '0;
            first_gate_d  = '0;
        end
    end

    // state and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wcnt_q        <= '0;
            mismatch_q    <= 1'b0;
            fail_flags_q  <= '0;
            mis_count_q   <= '0;
            stamp_q       <= '0;
            first_chan_q  <= '0;
            first_stamp_q <= '0;
            first_gold_q  <= '0;
            first_gate_q  <= '0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            mismatch_q    <= mismatch_d;
            fail_flags_q  <= fail_flags_d;
            mis_count_q   <= mis_count_d;
            stamp_q       <= stamp_d;
            first_chan_q  <= first_chan_d;
            first_stamp_q <= first_stamp_d;
            first_gold_q  <= first_gold_d;
            first_gate_q  <= first_gate_d;
        end
    end

    assign mismatch    = mismatch_q;
    assign fail_flags  = fail_flags_q;
    assign mis_count   = mis_count_q;
    assign first_chan  = first_chan_q;
    assign first_stamp = first_stamp_q;
    assign first_gold  = first_gold_q;
    assign first_gate  = first_gate_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_miter_stream_cmp.sv
// tb_miter_stream_cmp: randomized bench comparing two monitor configurations against a behavioural model
module tb_miter_stream_cmp;
    localparam int LAT = 2;
    localparam logic [31:0] FLIP_L2B3 = 32'h0008_0000;
    localparam logic [31:0] FLIP_L03  = 32'h0100_0001;

    logic        clk = 1'b0;
    logic        rst, arm, clear, in_valid;
    logic [31:0] gold, gate, gold_xmask;
    logic [3:0]  chan_en;

    logic        mm0, mm1;
    logic [3:0]  ff0, ff1;
    logic [15:0] mc0, fs0;
    logic [7:0]  mc1, fs1;
    logic [2:0]  fc0, fc1;
    logic [7:0]  fg0, ft0, fg1, ft1;
    logic [1:0]  st0, st1;

    int checks = 0;
    int errors = 0;
    logic [31:0] gp [2] = '{32'h0, 32'h0};

    // behavioural model state, index 0: stop-on-fail 16-bit, index 1: keep-counting 8-bit
    logic [31:0] hg [LAT] = '{default: 32'h0};
    logic [31:0] hx [LAT] = '{default: 32'h0};
    logic        hv [LAT] = '{default: 1'b0};
    logic [1:0]  ms [2] = '{2'd0, 2'd0};
    logic        mm [2] = '{1'b0, 1'b0};
    logic [3:0]  ef [2] = '{4'd0, 4'd0};
    logic [15:0] ec [2] = '{16'd0, 16'd0};
    logic [15:0] sc [2] = '{16'd0, 16'd0};
    logic [2:0]  fc [2] = '{3'd0, 3'd0};
    logic [15:0] fs [2] = '{16'd0, 16'd0};
    logic [7:0]  fg [2] = '{8'd0, 8'd0};
    logic [7:0]  ft [2] = '{8'd0, 8'd0};
    int          wc [2] = '{0, 0};
    logic [15:0] mx [2] = '{16'hFFFF, 16'h00FF};

    logic [57:0] obs0, exp0;
    logic [41:0] obs1, exp1;
    assign obs0 = {st0, mm0, ff0, mc0, fc0, fs0, fg0, ft0};
    assign obs1 = {st1, mm1, ff1, mc1, fc1, fs1, fg1, ft1};
    assign exp0 = {ms[0], mm[0], ef[0], ec[0], fc[0], fs[0], fg[0], ft[0]};
    assign exp1 = {ms[1], mm[1], ef[1], ec[1][7:0], fc[1], fs[1][7:0], fg[1], ft[1]};

    always #5 clk = ~clk;

    miter_stream_cmp #(.WIDTH(8), .CHANNELS(4), .LAT(LAT), .CNT_W(16), .STOP_FAIL(1'b1)) u_stop (
        .clk(clk), .rst(rst), .arm(arm), .clear(clear), .in_valid(in_valid),
        .gold(gold), .gate(gate), .gold_xmask(gold_xmask), .chan_en(chan_en),
        .mismatch(mm0), .fail_flags(ff0), .mis_count(mc0), .first_chan(fc0),
        .first_stamp(fs0), .first_gold(fg0), .first_gate(ft0), .state_o(st0));

    miter_stream_cmp #(.WIDTH(8), .CHANNELS(4), .LAT(LAT), .CNT_W(8), .STOP_FAIL(1'b0)) u_cont (
        .clk(clk), .rst(rst), .arm(arm), .clear(clear), .in_valid(in_valid),
        .gold(gold), .gate(gate), .gold_xmask(gold_xmask), .chan_en(chan_en),
        .mismatch(mm1), .fail_flags(ff1), .mis_count(mc1), .first_chan(fc1),
        .first_stamp(fs1), .first_gold(fg1), .first_gate(ft1), .state_o(st1));

    // model: state 0 idle, 1 warmup, 2 check, 3 failed; gold seen LAT cycles late
    always @(posedge clk or posedge rst) begin
        logic [31:0] d;
        logic [3:0]  lm;
        logic [2:0]  lo;
        logic        cmp;
        logic [1:0]  s;
        if (rst || clear) begin
            for (int k = 0; k < 2; k++) begin
                ms[k] = 0; mm[k] = 0; ef[k] = 0; ec[k] = 0; sc[k] = 0;
                fc[k] = 0; fs[k] = 0; fg[k] = 0; ft[k] = 0; wc[k] = 0;
            end
            for (int j = 0; j < LAT; j++) hv[j] = 1'b0;
        end else begin
            lm = 4'd0;
            lo = 3'd0;
            for (int i = 0; i < 4; i++) begin
                d = ((hg[LAT-1] ^ gate) & ~hx[LAT-1]) >> (8 * i);
                lm[i] = chan_en[i] && d[7:0] != 8'd0;
            end
            for (int i = 3; i >= 0; i--) if (lm[i]) lo = 3'(i);
            for (int k = 0; k < 2; k++) begin
                s = ms[k];
                cmp = hv[LAT-1] && in_valid && (s == 2 || (s == 3 && k == 1));
                mm[k] = cmp && lm != 4'd0;
                if (cmp) begin
                    ef[k] = ef[k] | lm;
                    if (lm != 4'd0 && ec[k] < mx[k]) ec[k] = ec[k] + 16'd1;
                    if (s == 2 && lm != 4'd0) begin
                        fc[k] = lo;
                        fs[k] = sc[k];
                        d = hg[LAT-1] >> (8 * lo);
                        fg[k] = d[7:0];
                        d = gate >> (8 * lo);
                        ft[k] = d[7:0];
                        ms[k] = 3;
                    end
                    if (sc[k] < mx[k]) sc[k] = sc[k] + 16'd1;
                end
                if (s == 0 && arm) begin
                    ms[k] = 1;
                    wc[k] = 0;
                end
                if (s == 1 && in_valid) begin
                    wc[k] = wc[k] + 1;
                    if (wc[k] == LAT) ms[k] = 2;
                end
            end
            for (int j = LAT - 1; j > 0; j--) begin
                hg[j] = hg[j-1]; hx[j] = hx[j-1]; hv[j] = hv[j-1];
            end
            hg[0] = gold; hx[0] = gold_xmask; hv[0] = in_valid;
        end
    end

    // one cycle of stimulus: fresh random gold, gate = gold from LAT cycles back with optional bit flips
    task automatic cyc(input logic iv, input logic [31:0] flip, input logic [31:0] xm);
        logic [31:0] ng;
        ng = $urandom;
        in_valid = iv;
        gold = ng;
        gold_xmask = xm;
        gate = gp[1] ^ flip;
        gp[1] = gp[0];
        gp[0] = ng;
        @(negedge clk);
    endtask

    task automatic restart();
        clear = 1'b1;
        cyc(1'b1, 32'h0, 32'h0);
        clear = 1'b0;
        arm = 1'b1;
        cyc(1'b1, 32'h0, 32'h0);
        arm = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b0; clear = 1'b0; in_valid = 1'b0;
        gold = '0; gate = '0; gold_xmask = '0; chan_en = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (obs0 !== 58'd0) begin errors++; $display("FAIL reset_outputs0 got=%h exp=0", obs0); end
        checks++; if (obs1 !== 42'd0) begin errors++; $display("FAIL reset_outputs1 got=%h exp=0", obs1); end
    endtask

    task automatic test_match();
        arm = 1'b1;
        cyc(1'b1, 32'h0, 32'h0);
        arm = 1'b0;
        checks++; if (st0 !== 2'd1) begin errors++; $display("FAIL arm_warmup got=%0d exp=1", st0); end
        repeat (22) begin
            cyc(1'b1, 32'h0, 32'h0);
            checks++; if (obs0 !== exp0) begin errors++; $display("FAIL match_model0 got=%h exp=%h", obs0, exp0); end
        end
        checks++; if ({st0, mm0, mc0} !== {2'd2, 1'b0, 16'd0}) begin
            errors++; $display("FAIL match_clean got st=%0d mm=%0b cnt=%0d exp st=2 mm=0 cnt=0", st0, mm0, mc0);
        end
    endtask

    task automatic test_first_fail();
        logic [31:0] f;
        logic hit;
        restart();
        for (int i = 0; i < 12; i++) begin
            f = (ms[0] == 2 && sc[0] == 16'd5) ? FLIP_L2B3 : 32'h0;
            hit = f != 32'h0;
            cyc(1'b1, f, 32'h0);
            if (hit) begin
                checks++; if ({mm0, st0} !== {1'b1, 2'd3}) begin
                    errors++; $display("FAIL first_fail_next got mm=%0b st=%0d exp mm=1 st=3", mm0, st0);
                end
            end
            checks++; if (obs0 !== exp0) begin errors++; $display("FAIL first_model0 got=%h exp=%h", obs0, exp0); end
            checks++; if (obs1 !== exp1) begin errors++; $display("FAIL first_model1 got=%h exp=%h", obs1, exp1); end
        end
        checks++; if ({ff0, fc0, fs0, st0} !== {4'b0100, 3'd2, 16'd5, 2'd3}) begin
            errors++; $display("FAIL first_capture got ff=%b fc=%0d fs=%0d st=%0d exp ff=0100 fc=2 fs=5 st=3", ff0, fc0, fs0, st0);
        end
        checks++; if ((fg0 ^ ft0) !== 8'h08) begin errors++; $display("FAIL first_diff got=%h exp=08", fg0 ^ ft0); end
    endtask

    task automatic test_mask();
        logic [31:0] f;
        restart();
        for (int i = 0; i < 12; i++) begin
            f = (ms[0] == 2 && sc[0] == 16'd5) ? FLIP_L2B3 : 32'h0;
            cyc(1'b1, f, FLIP_L2B3);
        end
        checks++; if ({st0, ff0, mc0} !== {2'd2, 4'd0, 16'd0}) begin
            errors++; $display("FAIL mask_xmask got st=%0d ff=%b cnt=%0d exp st=2 ff=0000 cnt=0", st0, ff0, mc0);
        end
        chan_en = 4'b1011;
        restart();
        for (int i = 0; i < 12; i++) begin
            f = (ms[0] == 2 && sc[0] == 16'd5) ? FLIP_L2B3 : 32'h0;
            cyc(1'b1, f, 32'h0);
        end
        checks++; if ({st0, ff0, mc0} !== {2'd2, 4'd0, 16'd0}) begin
            errors++; $display("FAIL mask_chan_en got st=%0d ff=%b cnt=%0d exp st=2 ff=0000 cnt=0", st0, ff0, mc0);
        end
        chan_en = 4'hF;
    endtask

    task automatic test_warmup_gaps();
        int n;
        logic [1:0] e;
        restart();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(i % 2 == 0, 32'h0, 32'h0);
            n += (i % 2 == 0) ? 1 : 0;
            e = n >= LAT ? 2'd2 : 2'd1;
            checks++; if (st0 !== e) begin errors++; $display("FAIL warmup_gap_%0d got=%0d exp=%0d", i, st0, e); end
        end
    endtask

    task automatic test_random();
        logic [31:0] f;
        for (int r = 0; r < 3; r++) begin
            restart();
            for (int i = 0; i < 100; i++) begin
                chan_en = 4'($urandom);
                f = ($urandom_range(0, 11) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
                cyc($urandom_range(0, 3) != 0, f, $urandom & $urandom & $urandom);
                checks++; if (obs0 !== exp0) begin errors++; $display("FAIL rand_model0 r=%0d i=%0d got=%h exp=%h", r, i, obs0, exp0); end
                checks++; if (obs1 !== exp1) begin errors++; $display("FAIL rand_model1 r=%0d i=%0d got=%h exp=%h", r, i, obs1, exp1); end
            end
        end
        chan_en = 4'hF;
    endtask

    task automatic test_saturation();
        restart();
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, FLIP_L03, 32'h0);
            checks++; if (obs1 !== exp1) begin errors++; $display("FAIL sat_model1 i=%0d got=%h exp=%h", i, obs1, exp1); end
        end
        checks++; if ({mc1, fc1, ff1, st1} !== {8'hFF, 3'd0, 4'b1001, 2'd3}) begin
            errors++; $display("FAIL sat_count got cnt=%h fc=%0d ff=%b st=%0d exp cnt=ff fc=0 ff=1001 st=3", mc1, fc1, ff1, st1);
        end
        checks++; if ({mc0, ff0, st0} !== {16'd1, 4'b1001, 2'd3}) begin
            errors++; $display("FAIL sat_stop got cnt=%0d ff=%b st=%0d exp cnt=1 ff=1001 st=3", mc0, ff0, st0);
        end
    endtask

    task automatic test_rst_clear();
        #2 rst = 1'b1;
        #1;
        checks++; if (obs0 !== 58'd0) begin errors++; $display("FAIL rst_async0 got=%h exp=0", obs0); end
        checks++; if (obs1 !== 42'd0) begin errors++; $display("FAIL rst_async1 got=%h exp=0", obs1); end
        #1 rst = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        arm = 1'b1;
        cyc(1'b1, 32'h0, 32'h0);
        clear = 1'b0;
        arm = 1'b0;
        checks++; if (obs0 !== 58'd0) begin errors++; $display("FAIL clear_arm0 got=%h exp=0", obs0); end
        checks++; if (obs1 !== exp1) begin errors++; $display("FAIL clear_arm1 got=%h exp=%h", obs1, exp1); end
        cyc(1'b1, 32'h0, 32'h0);
        checks++; if (st0 !== 2'd0) begin errors++; $display("FAIL clear_idle got=%0d exp=0", st0); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_first_fail();
        test_mask();
        test_warmup_gaps();
        test_random();
        test_saturation();
        test_rst_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
